// File: rtl/pulse_sync_pkg.sv
// Shared types and helpers for the multi-channel pulse synchronizer.
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Stable-cycle counter width; never narrower than one bit.
    function automatic int unsigned fcnt_width(int unsigned filt_cyc);
        int unsigned w;
        w = $clog2(filt_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_sync_multi_if.sv
// Bundle of the per-channel level inputs, controls and event outputs.
interface pulse_sync_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
);
    logic [NUM_CH-1:0]       async_in;
    logic [2*NUM_CH-1:0]     edge_mode;
    logic [NUM_CH-1:0]       cnt_clr;
    logic [NUM_CH-1:0]       pulse_out;
    logic [NUM_CH-1:0]       level_out;
    logic [NUM_CH*CNT_W-1:0] evt_cnt;
    logic [NUM_CH-1:0]       cnt_sat;

    modport master (
        output async_in, edge_mode, cnt_clr,
        input  pulse_out, level_out, evt_cnt, cnt_sat
    );

    modport slave (
        input  async_in, edge_mode, cnt_clr,
        output pulse_out, level_out, evt_cnt, cnt_sat
    );
endinterface

// File: rtl/pulse_sync_ch.sv
// One channel: synchronizer chain, stability filter, edge qualifier and saturating counter.
module pulse_sync_ch
    import pulse_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             rd_clk,
    input  logic             rd_reset,
    input  logic             async_in,
    input  logic [1:0]       edge_mode,
    input  logic             cnt_clr,
    output logic             pulse_out,
    output logic             level_out,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             cnt_sat
);

    localparam int unsigned    FcntW   = fcnt_width(FILT_CYC);
    localparam logic [FcntW-1:0] FiltMax = FcntW'(FILT_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;
    logic                   filt_q, filt_d;
    logic [FcntW-1:0]       fcnt_q, fcnt_d;
    logic                   upd, ev;
    logic                   rise_en, fall_en;
    logic                   pulse_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    edge_mode_e             mode;

    assign syn  = sync_q[SYNC_STAGES-1];
    assign mode = edge_mode_e'(edge_mode);

    // A change is accepted only after FILT_CYC extra cycles of disagreement.
    always_comb begin
        fcnt_d = '0;
        filt_d = filt_q;
        upd    = 1'b0;
        if (syn != filt_q) begin
            if (fcnt_q == FiltMax) begin
                upd    = 1'b1;
                filt_d = syn;
            end else begin
                fcnt_d = fcnt_q + FcntW'(1);
            end
        end
    end

    assign rise_en = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    assign fall_en = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    assign ev      = upd & ((syn & rise_en) | (~syn & fall_en));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = ev ? CNT_W'(1) : '0;
        end else if (ev && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            sync_q  <= '0;
            filt_q  <= 1'b0;
            fcnt_q  <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            pulse_q <= ev;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_out = pulse_q;
    assign level_out = filt_q;
    assign evt_cnt   = cnt_q;
    assign cnt_sat   = &cnt_q;

endmodule

// File: rtl/pulse_sync_multi.sv
// NUM_CH independent pulse synchronizer channels sharing the rd_clk domain.
module pulse_sync_multi
    import pulse_sync_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               rd_clk,
    input  logic               rd_reset,
    pulse_sync_multi_if.slave  bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_sync_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC),
            .CNT_W       (CNT_W)
        ) u_ch (
            .rd_clk    (rd_clk),
            .rd_reset  (rd_reset),
            .async_in  (bus.async_in[i]),
            .edge_mode (bus.edge_mode[2*i +: 2]),
            .cnt_clr   (bus.cnt_clr[i]),
            .pulse_out (bus.pulse_out[i]),
            .level_out (bus.level_out[i]),
            .evt_cnt   (bus.evt_cnt[CNT_W*i +: CNT_W]),
            .cnt_sat   (bus.cnt_sat[i])
        );
    end

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Directed bench: dut_a (FILT_CYC=0, CNT_W=4, 4 channels), dut_b (FILT_CYC=3, 1 channel).
module tb_pulse_sync_multi;
    import pulse_sync_pkg::*;

    logic rd_clk = 1'b0;
    logic rd_reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 rd_clk = ~rd_clk;

    pulse_sync_multi_if #(.NUM_CH(4), .CNT_W(4)) bus_a ();
    pulse_sync_multi_if #(.NUM_CH(1), .CNT_W(8)) bus_b ();

    pulse_sync_multi #(.NUM_CH(4), .SYNC_STAGES(2), .FILT_CYC(0), .CNT_W(4)) dut_a (
        .rd_clk   (rd_clk),
        .rd_reset (rd_reset),
        .bus      (bus_a)
    );

    pulse_sync_multi #(.NUM_CH(1), .SYNC_STAGES(2), .FILT_CYC(3), .CNT_W(8)) dut_b (
        .rd_clk   (rd_clk),
        .rd_reset (rd_reset),
        .bus      (bus_b)
    );

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_p, exp_l;
        bus_a.async_in  = 4'b0001;
        bus_a.edge_mode = {EDGE_OFF, EDGE_OFF, EDGE_OFF, EDGE_RISE};
        bus_a.cnt_clr   = '0;
        bus_b.async_in  = '0;
        bus_b.edge_mode = EDGE_BOTH;
        bus_b.cnt_clr   = '0;
        rd_reset = 1'b1;
        #2 rd_reset = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus_a.pulse_out !== 4'h0) begin n_fail++; $display("FAIL rst_pulse: got %h expected 0", bus_a.pulse_out); end
        n_checks++; if (bus_a.level_out !== 4'h0) begin n_fail++; $display("FAIL rst_level: got %h expected 0", bus_a.level_out); end
        n_checks++; if (bus_a.evt_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", bus_a.evt_cnt); end
        n_checks++; if (bus_a.cnt_sat !== 4'h0) begin n_fail++; $display("FAIL rst_sat: got %h expected 0", bus_a.cnt_sat); end
        n_checks++; if (bus_b.level_out !== 1'b0 || bus_b.evt_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_b: got level %b cnt %0d expected 0 0", bus_b.level_out, bus_b.evt_cnt); end
        rd_reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_p = (k == 3) ? 4'b0001 : 4'b0000;
            exp_l = (k >= 3) ? 4'b0001 : 4'b0000;
            n_checks++; if (bus_a.pulse_out !== exp_p) begin n_fail++; $display("FAIL rel_pulse cyc%0d: got %h expected %h", k, bus_a.pulse_out, exp_p); end
            n_checks++; if (bus_a.level_out !== exp_l) begin n_fail++; $display("FAIL rel_level cyc%0d: got %h expected %h", k, bus_a.level_out, exp_l); end
        end
        n_checks++; if (bus_a.evt_cnt !== 16'h0001) begin n_fail++; $display("FAIL rel_cnt: got %h expected 0001", bus_a.evt_cnt); end
    endtask

    task automatic test_modes();
        int pc[4];
        bus_a.edge_mode = '0;
        bus_a.async_in  = '0;
        repeat (6) tick();
        bus_a.cnt_clr = 4'hF;
        tick();
        bus_a.cnt_clr = '0;
        n_checks++; if (bus_a.evt_cnt !== 16'h0 || bus_a.level_out !== 4'h0) begin n_fail++; $display("FAIL mode_pre: got cnt %h level %h expected 0 0", bus_a.evt_cnt, bus_a.level_out); end
        bus_a.edge_mode = {EDGE_BOTH, EDGE_FALL, EDGE_RISE, EDGE_OFF};
        for (int i = 0; i < 4; i++) pc[i] = 0;
        bus_a.async_in = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            for (int i = 0; i < 4; i++) pc[i] += int'(bus_a.pulse_out[i]);
        end
        n_checks++; if (bus_a.level_out !== 4'hF) begin n_fail++; $display("FAIL mode_level_hi: got %h expected f", bus_a.level_out); end
        bus_a.async_in = 4'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            for (int i = 0; i < 4; i++) pc[i] += int'(bus_a.pulse_out[i]);
        end
        n_checks++; if (bus_a.level_out !== 4'h0) begin n_fail++; $display("FAIL mode_level_lo: got %h expected 0", bus_a.level_out); end
        n_checks++; if (pc[0] != 0) begin n_fail++; $display("FAIL mode_off_pulses: got %0d expected 0", pc[0]); end
        n_checks++; if (pc[1] != 1) begin n_fail++; $display("FAIL mode_rise_pulses: got %0d expected 1", pc[1]); end
        n_checks++; if (pc[2] != 1) begin n_fail++; $display("FAIL mode_fall_pulses: got %0d expected 1", pc[2]); end
        n_checks++; if (pc[3] != 2) begin n_fail++; $display("FAIL mode_both_pulses: got %0d expected 2", pc[3]); end
        n_checks++; if (bus_a.evt_cnt !== 16'h2110) begin n_fail++; $display("FAIL mode_cnts: got %h expected 2110", bus_a.evt_cnt); end
    endtask

    task automatic test_back_to_back();
        int pc, run, best;
        bus_a.cnt_clr = 4'hF;
        tick();
        bus_a.cnt_clr   = '0;
        bus_a.edge_mode = {EDGE_OFF, EDGE_OFF, EDGE_BOTH, EDGE_OFF};
        pc = 0; run = 0; best = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) bus_a.async_in[1] = ~bus_a.async_in[1];
            tick();
            if (bus_a.pulse_out[1]) begin pc++; run++; if (run > best) best = run; end
            else run = 0;
        end
        n_checks++; if (pc != 6) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 6", pc); end
        n_checks++; if (best != 6) begin n_fail++; $display("FAIL b2b_run: got %0d expected 6", best); end
        n_checks++; if (bus_a.evt_cnt[7:4] !== 4'd6) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 6", bus_a.evt_cnt[7:4]); end
    endtask

    task automatic test_saturation();
        bus_a.edge_mode = {EDGE_OFF, EDGE_OFF, EDGE_RISE, EDGE_OFF};
        bus_a.cnt_clr   = 4'b0010;
        tick();
        bus_a.cnt_clr = '0;
        for (int e = 0; e < 17; e++) begin
            bus_a.async_in[1] = 1'b1;
            repeat (4) tick();
            bus_a.async_in[1] = 1'b0;
            repeat (4) tick();
        end
        n_checks++; if (bus_a.evt_cnt[7:4] !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 15", bus_a.evt_cnt[7:4]); end
        n_checks++; if (bus_a.cnt_sat !== 4'b0010) begin n_fail++; $display("FAIL sat_flag: got %b expected 0010", bus_a.cnt_sat); end
        bus_a.async_in[1] = 1'b1;
        repeat (2) tick();
        bus_a.cnt_clr = 4'b0010;
        tick();
        bus_a.cnt_clr = '0;
        n_checks++; if (bus_a.pulse_out[1] !== 1'b1) begin n_fail++; $display("FAIL clr_ev_pulse: got %b expected 1", bus_a.pulse_out[1]); end
        n_checks++; if (bus_a.evt_cnt[7:4] !== 4'd1) begin n_fail++; $display("FAIL clr_ev_cnt: got %0d expected 1", bus_a.evt_cnt[7:4]); end
        bus_a.async_in[1] = 1'b0;
        repeat (6) tick();
        n_checks++; if (bus_a.evt_cnt[7:4] !== 4'd1) begin n_fail++; $display("FAIL clr_ev_hold: got %0d expected 1", bus_a.evt_cnt[7:4]); end
        bus_a.cnt_clr = 4'b0010;
        tick();
        bus_a.cnt_clr = '0;
        n_checks++; if (bus_a.evt_cnt[7:4] !== 4'd0 || bus_a.cnt_sat[1] !== 1'b0) begin n_fail++; $display("FAIL clr_alone: got cnt %0d sat %b expected 0 0", bus_a.evt_cnt[7:4], bus_a.cnt_sat[1]); end
    endtask

    task automatic test_filter();
        int pc, rise_at, fall_at;
        logic lvl_seen;
        bus_b.edge_mode = EDGE_BOTH;
        pc = 0; lvl_seen = 1'b0;
        bus_b.async_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) bus_b.async_in = 1'b0;
            pc += int'(bus_b.pulse_out);
            lvl_seen |= bus_b.level_out;
        end
        n_checks++; if (pc != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", pc); end
        n_checks++; if (lvl_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_level: got %b expected 0", lvl_seen); end
        pc = 0; rise_at = -1; fall_at = -1;
        bus_b.async_in = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 5) bus_b.async_in = 1'b0;
            if (bus_b.pulse_out) begin
                pc++;
                if (rise_at < 0) rise_at = k;
                else fall_at = k;
            end
            if (k == 6) begin
                n_checks++; if (bus_b.level_out !== 1'b1) begin n_fail++; $display("FAIL filt_level_rise: got %b expected 1", bus_b.level_out); end
            end
        end
        n_checks++; if (rise_at != 6) begin n_fail++; $display("FAIL filt_rise_cyc: got %0d expected 6", rise_at); end
        n_checks++; if (fall_at != 11) begin n_fail++; $display("FAIL filt_fall_cyc: got %0d expected 11", fall_at); end
        n_checks++; if (pc != 2 || bus_b.evt_cnt !== 8'd2) begin n_fail++; $display("FAIL filt_count: got pulses %0d cnt %0d expected 2 2", pc, bus_b.evt_cnt); end
        n_checks++; if (bus_b.level_out !== 1'b0) begin n_fail++; $display("FAIL filt_level_end: got %b expected 0", bus_b.level_out); end
    endtask

    task automatic test_mid_reset();
        int pc;
        bus_a.edge_mode = {EDGE_BOTH, EDGE_OFF, EDGE_RISE, EDGE_OFF};
        bus_a.async_in[1] = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus_a.level_out[1] !== 1'b1 || bus_a.evt_cnt[7:4] !== 4'd1) begin n_fail++; $display("FAIL mid_pre: got level %b cnt %0d expected 1 1", bus_a.level_out[1], bus_a.evt_cnt[7:4]); end
        bus_a.async_in[3] = 1'b1;
        tick();
        #2;
        rd_reset = 1'b0;
        bus_a.async_in = '0;
        #1;
        n_checks++; if (bus_a.level_out !== 4'h0 || bus_a.pulse_out !== 4'h0) begin n_fail++; $display("FAIL mid_rst_out: got level %h pulse %h expected 0 0", bus_a.level_out, bus_a.pulse_out); end
        n_checks++; if (bus_a.evt_cnt !== 16'h0 || bus_a.cnt_sat !== 4'h0) begin n_fail++; $display("FAIL mid_rst_cnt: got cnt %h sat %h expected 0 0", bus_a.evt_cnt, bus_a.cnt_sat); end
        repeat (2) tick();
        rd_reset = 1'b1;
        pc = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            pc += int'(bus_a.pulse_out != 4'h0);
        end
        n_checks++; if (pc != 0 || bus_a.level_out !== 4'h0 || bus_a.evt_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_post: got pulses %0d level %h cnt %h expected 0 0 0", pc, bus_a.level_out, bus_a.evt_cnt); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_saturation();
        test_filter();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
